// File: rtl/wb_req_bridge_if.sv
// wb_req_bridge_if: Wishbone slave side plus downstream device request/reply.
// slave = bridge view, master = SoC/device-model view.
interface wb_req_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        dev_valid;
  logic [3:0]  dev_wstrb;
  logic [31:0] dev_wdata;
  logic [31:0] dev_addr;
  logic        dev_ready;
  logic [31:0] dev_rdata;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  dev_ready, dev_rdata,
    output wbs_ack_o, wbs_dat_o,
    output dev_valid, dev_wstrb,
    output dev_wdata, dev_addr
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output dev_ready, dev_rdata,
    input  wbs_ack_o, wbs_dat_o,
    input  dev_valid, dev_wstrb,
    input  dev_wdata, dev_addr
  );
endinterface

// File: rtl/wb_req_bridge.sv
// wb_req_bridge: Wishbone classic slave that forwards a windowed request
// to a valid/ready device, with bus timeout, abort and txn counter.
module wb_req_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_DATA  = 32'hBADC_0FFE
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_req_bridge_if.slave        bus,
  input  logic                  clr_err,
  output logic                  err_sticky,
  output logic [15:0]           txn_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_wstrb;
  logic        r_we;
  logic [31:0] r_rdata;
  logic [31:0] r_dato;
  logic        r_ack;
  logic        r_valid;
  logic        r_abort;
  logic [15:0] r_tcnt;
  logic        r_err;
  logic [15:0] r_txn;

  logic        w_hit;
  logic        w_tmo;
  logic        w_abort;
  logic        w_done;
  logic [31:0] w_rd_next;

  assign w_hit = bus.wbs_cyc_i & bus.wbs_stb_i &
                 ((bus.wbs_adr_i & ADDR_MASK) ==
                  (BASE_ADDR & ADDR_MASK));

  assign w_tmo   = (TIMEOUT != 0) && (r_tcnt == TLIM);
  assign w_abort = r_abort | ~bus.wbs_cyc_i;
  assign w_done  = bus.dev_ready | w_tmo;

  // A device reply wins over a timeout landing on the same cycle.
  always_comb begin
    w_rd_next = 32'h0;
    if (!r_we) begin
      w_rd_next = bus.dev_ready ? bus.dev_rdata : ERR_DATA;
    end
  end

  // Main request FSM with registered bus/device outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_adr   <= 32'h0;
      r_dat   <= 32'h0;
      r_wstrb <= 4'h0;
      r_we    <= 1'b0;
      r_rdata <= 32'h0;
      r_dato  <= 32'h0;
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      r_abort <= 1'b0;
      r_tcnt  <= 16'h0;
      r_err   <= 1'b0;
      r_txn   <= 16'h0;
    end else begin
      r_ack  <= 1'b0;
      r_dato <= 32'h0;
      if (clr_err) begin
        r_err <= 1'b0;
      end
      unique case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_adr   <= bus.wbs_adr_i;
            r_dat   <= bus.wbs_dat_i;
            r_wstrb <= bus.wbs_sel_i & {4{bus.wbs_we_i}};
            r_we    <= bus.wbs_we_i;
            r_tcnt  <= 16'h0;
            r_abort <= 1'b0;
            r_valid <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          r_abort <= w_abort;
          if (w_done) begin
            r_valid <= 1'b0;
            r_txn   <= r_txn + 16'd1;
            r_rdata <= w_rd_next;
            if (!bus.dev_ready) begin
              r_err <= 1'b1;
            end
            if (w_abort) begin
              r_state <= IDLE;
            end else begin
              r_state <= ACK;
              r_ack   <= 1'b1;
              r_dato  <= w_rd_next;
            end
          end else begin
            r_tcnt <= r_tcnt + 16'd1;
          end
        end
        ACK: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.wbs_ack_o = r_ack;
  assign bus.wbs_dat_o = r_dato;
  assign bus.dev_valid = r_valid;
  assign bus.dev_wstrb = r_wstrb;
  assign bus.dev_wdata = r_dat;
  assign bus.dev_addr  = r_adr;
  assign err_sticky    = r_err;
  assign txn_count     = r_txn;

endmodule
